// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package memory_bus_pkg;

  // Wait counter width; wide enough for LATENCY up to 15.
  localparam int CNT_W = 4;

  // Index of a requester (0 or 1).
  typedef logic req_idx_t;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface memory_bus_arbiter_if;
  import memory_bus_pkg::*;

  logic        req0_memory_request;
  logic [31:0] req0_memory_address;
  logic        req0_memory_write_enable;
  logic [31:0] req0_memory_write_data;
  logic [31:0] req0_memory_read_data;
  logic        req0_memory_ready;

  logic        req1_memory_request;
  logic [31:0] req1_memory_address;
  logic        req1_memory_write_enable;
  logic [31:0] req1_memory_write_data;
  logic [31:0] req1_memory_read_data;
  logic        req1_memory_ready;

  logic [31:0] memory_address;
  logic        memory_write_enable;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;

  req_idx_t    grant_owner;
  logic        busy;

  modport slave (
    input  req0_memory_request, req0_memory_address,
    input  req0_memory_write_enable, req0_memory_write_data,
    input  req1_memory_request, req1_memory_address,
    input  req1_memory_write_enable, req1_memory_write_data,
    input  memory_read_data,
    output req0_memory_read_data, req0_memory_ready,
    output req1_memory_read_data, req1_memory_ready,
    output memory_address, memory_write_enable, memory_write_data,
    output grant_owner, busy
  );

  modport master (
    output req0_memory_request, req0_memory_address,
    output req0_memory_write_enable, req0_memory_write_data,
    output req1_memory_request, req1_memory_address,
    output req1_memory_write_enable, req1_memory_write_data,
    output memory_read_data,
    input  req0_memory_read_data, req0_memory_ready,
    input  req1_memory_read_data, req1_memory_ready,
    input  memory_address, memory_write_enable, memory_write_data,
    input  grant_owner, busy
  );

endinterface

// File: rtl/memory_bus_arbiter_rr.sv
// Two-way round-robin winner selection. The pointer names the requester
// that wins a tie; a lone request always wins.
module round_robin_arbiter_2
  import memory_bus_pkg::*;
(
  input  logic     i_req0,
  input  logic     i_req1,
  input  req_idx_t i_ptr,
  output logic     o_valid,
  output req_idx_t o_winner
);

  // Pick the pointer on contention, otherwise whichever requester is active.
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = 1'b0;
    if (i_req0 && i_req1) begin
      o_winner = i_ptr;
    end else if (i_req1) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates two requesters onto one fixed-latency shared memory port.
// A grant latches the winner's access, waits LATENCY cycles, then spends
// one RESPOND cycle pulsing ready (and the write strobe for stores).
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  memory_bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  req_idx_t         r_ptr;
  req_idx_t         r_owner;
  req_idx_t         w_winner;
  logic             w_win_valid;
  logic             w_owner_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;

  round_robin_arbiter_2 u_rr (
    .i_req0   (bus.req0_memory_request),
    .i_req1   (bus.req1_memory_request),
    .i_ptr    (r_ptr),
    .o_valid  (w_win_valid),
    .o_winner (w_winner)
  );

  // Only the owner's request line matters once a grant is taken.
  assign w_owner_req = r_owner ? bus.req1_memory_request : bus.req0_memory_request;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; an owner dropping its request during WAIT aborts.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (!w_owner_req)           w_next_state = ST_IDLE;
        else if (r_cnt == LAST_CNT) w_next_state = ST_RESPOND;
      end
      ST_RESPOND: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Grant latches, wait counter, read-data capture and pointer update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_owner <= w_winner;
            r_cnt   <= '0;
            r_addr  <= w_winner ? bus.req1_memory_address      : bus.req0_memory_address;
            r_we    <= w_winner ? bus.req1_memory_write_enable : bus.req0_memory_write_enable;
            r_wdata <= w_winner ? bus.req1_memory_write_data   : bus.req0_memory_write_data;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_next_state == ST_RESPOND && !r_we) begin
            if (r_owner) r_rdata1 <= bus.memory_read_data;
            else         r_rdata0 <= bus.memory_read_data;
          end
        end
        ST_RESPOND: begin
          r_ptr <= ~r_owner;
        end
        default: ;
      endcase
    end
  end

  assign bus.memory_address        = r_addr;
  assign bus.memory_write_data     = r_wdata;
  assign bus.memory_write_enable   = (r_state == ST_RESPOND) && r_we;
  assign bus.req0_memory_ready     = (r_state == ST_RESPOND) && !r_owner;
  assign bus.req1_memory_ready     = (r_state == ST_RESPOND) && r_owner;
  assign bus.req0_memory_read_data = r_rdata0;
  assign bus.req1_memory_read_data = r_rdata1;
  assign bus.grant_owner           = r_owner;
  assign bus.busy                  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: transaction table, hand-built corner
// sequences and random traffic, all scored every cycle against a
// timestamp-based transaction model.
module tb_memory_bus_arbiter;

  localparam int L = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_bus_arbiter_if bif();

  memory_bus_arbiter #(.LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // Shared memory: combinational read, write on the strobe, bench preload port.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic        pre_en = 1'b0;
  logic [7:0]  pre_a  = 8'h0;
  logic [31:0] pre_d  = 32'h0;
  assign bif.memory_read_data = mem[bif.memory_address[7:0]];
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (bif.memory_write_enable) mem[bif.memory_address[7:0]] <= bif.memory_write_data;
  end

  int checks = 0;
  int errors = 0;

  // Transaction model state.
  int          e_now   = 0;
  bit          m_active = 0;
  bit          m_owner  = 0;
  bit          m_ptr    = 0;
  bit          m_resp   = 0;
  bit          m_we     = 0;
  int          m_gedge  = 0;
  int          m_free   = 0;
  logic [31:0] m_addr   = 0;
  logic [31:0] m_wd     = 0;
  logic [31:0] m_rd [2] = '{32'h0, 32'h0};
  logic [31:0] mm [0:255] = '{default: 32'h0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic r, input logic [31:0] a,
                         input logic we, input logic [31:0] d);
    if (id == 0) begin
      bif.req0_memory_request = r; bif.req0_memory_address = a;
      bif.req0_memory_write_enable = we; bif.req0_memory_write_data = d;
    end else begin
      bif.req1_memory_request = r; bif.req1_memory_address = a;
      bif.req1_memory_write_enable = we; bif.req1_memory_write_data = d;
    end
  endtask

  function automatic logic get_rdy(input int id);
    return (id == 0) ? bif.req0_memory_ready : bif.req1_memory_ready;
  endfunction

  // One clock: snapshot inputs, advance, update the model, compare everything.
  task automatic tick();
    logic        s_rst;
    logic [1:0]  s_req, s_we;
    logic [31:0] s_a [2];
    logic [31:0] s_d [2];
    int          k;
    bit          w;
    s_rst  = rst_n;
    s_req  = {bif.req1_memory_request, bif.req0_memory_request};
    s_we   = {bif.req1_memory_write_enable, bif.req0_memory_write_enable};
    s_a[0] = bif.req0_memory_address;    s_a[1] = bif.req1_memory_address;
    s_d[0] = bif.req0_memory_write_data; s_d[1] = bif.req1_memory_write_data;
    @(posedge clk);
    #1;
    e_now++;
    m_resp = 0;
    if (!s_rst) begin
      m_active = 0; m_owner = 0; m_ptr = 0; m_we = 0;
      m_addr = 0; m_wd = 0; m_rd[0] = 0; m_rd[1] = 0;
      m_free = e_now + 1;
    end else if (m_active) begin
      k = e_now - m_gedge;
      if (!s_req[m_owner]) begin
        m_active = 0;
        m_free   = e_now + 1;
      end else if (k == L) begin
        m_resp   = 1;
        m_active = 0;
        m_free   = e_now + 2;
        m_ptr    = !m_owner;
        if (m_we) mm[m_addr[7:0]] = m_wd;
        else      m_rd[m_owner]   = mm[m_addr[7:0]];
      end
    end else if (e_now >= m_free && (s_req[0] || s_req[1])) begin
      w = (s_req[0] && s_req[1]) ? m_ptr : s_req[1];
      m_owner  = w;
      m_addr   = s_a[w];
      m_we     = s_we[w];
      m_wd     = s_d[w];
      m_active = 1;
      m_gedge  = e_now;
    end
    chk("ready0",    bif.req0_memory_ready,     m_resp && !m_owner);
    chk("ready1",    bif.req1_memory_ready,     m_resp && m_owner);
    chk("busy",      bif.busy,                  m_active || m_resp);
    chk("mem_we",    bif.memory_write_enable,   m_resp && m_we);
    chk("owner",     bif.grant_owner,           m_owner);
    chk("mem_addr",  bif.memory_address,        m_addr);
    chk("mem_wdata", bif.memory_write_data,     m_wd);
    chk("rdata0",    bif.req0_memory_read_data, m_rd[0]);
    chk("rdata1",    bif.req1_memory_read_data, m_rd[1]);
  endtask

  task automatic preset(input logic [31:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_a = a[7:0]; pre_d = d;
    mm[a[7:0]] = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready0"}, bif.req0_memory_ready, 0);
    chk({tag, "_ready1"}, bif.req1_memory_ready, 0);
    chk({tag, "_busy"},   bif.busy, 0);
    chk({tag, "_we"},     bif.memory_write_enable, 0);
    chk({tag, "_owner"},  bif.grant_owner, 0);
    chk({tag, "_addr"},   bif.memory_address, 0);
    chk({tag, "_wdata"},  bif.memory_write_data, 0);
    chk({tag, "_rd0"},    bif.req0_memory_read_data, 0);
    chk({tag, "_rd1"},    bif.req1_memory_read_data, 0);
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'h0000_0101);
  endfunction

  // Single transaction from one requester; reports ready edge and strobes.
  task automatic do_txn(input int id, input logic [31:0] a, input logic we,
                        input logic [31:0] d, output int n_rdy, output int n_other,
                        output int n_stb, output logic [31:0] stb_a,
                        output logic [31:0] stb_d);
    n_rdy = -1; n_other = 0; n_stb = 0; stb_a = 0; stb_d = 0;
    set_req(id, 1, a, we, d);
    for (int c = 1; c <= L + 6; c++) begin
      tick();
      if (bif.memory_write_enable) begin
        n_stb++; stb_a = bif.memory_address; stb_d = bif.memory_write_data;
      end
      if (get_rdy(1 - id)) n_other++;
      if (get_rdy(id)) begin
        if (n_rdy < 0) n_rdy = c;
        set_req(id, 0, 0, 0, 0);
      end
    end
  endtask

  // Four-word line fill by req0, optionally with one req1 read raised after the first grant.
  task automatic line_fill(input logic [31:0] base, input bit with_r1,
                           output int t_first, output int t_last, output int t_r1);
    int words;
    int prev;
    words = 0; prev = -1; t_first = -1; t_last = -1; t_r1 = -1;
    set_req(0, 1, base, 0, 0);
    for (int c = 1; c <= 8 * (L + 2) + 8 && words < 4; c++) begin
      tick();
      if (with_r1 && c == 1) set_req(1, 1, base + 32'h10, 0, 0);
      if (bif.req1_memory_ready) begin
        t_r1 = c;
        set_req(1, 0, 0, 0, 0);
      end
      if (bif.req0_memory_ready) begin
        chk("fill_data", bif.req0_memory_read_data, pat(base + words));
        if (!with_r1 && prev >= 0) chk("fill_spacing", c - prev, L + 2);
        if (words == 0) t_first = c;
        t_last = c;
        prev   = c;
        words++;
        if (words < 4) set_req(0, 1, base + words, 0, 0);
        else           set_req(0, 0, 0, 0, 0);
      end
    end
    chk("fill_words", words, 4);
    set_req(1, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic        pre;
    logic [31:0] pre_d;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv [6];
    int          n_rdy, n_other, n_stb, first, t0, t1, t2, nr, stb;
    int          order [4];
    int          when  [4];
    logic [31:0] sa, sd;

    tv[0] = '{1'b0, 32'h0000_0010, 1'b0, 32'h0,         1'b1, 32'h0011_2233, 32'h0011_2233};
    tv[1] = '{1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         32'h0};
    tv[2] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,         1'b0, 32'h0,         32'hDEAD_BEEF};
    tv[3] = '{1'b0, 32'h0000_0020, 1'b1, 32'h1234_5678, 1'b0, 32'h0,         32'h0011_2233};
    tv[4] = '{1'b0, 32'h0000_0020, 1'b0, 32'h0,         1'b0, 32'h0,         32'h1234_5678};
    tv[5] = '{1'b1, 32'h0000_007F, 1'b0, 32'h0,         1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D};

    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Table of single transactions.
    for (int i = 0; i < 6; i++) begin
      if (tv[i].pre) preset(tv[i].addr, tv[i].pre_d);
      do_txn(int'(tv[i].id), tv[i].addr, tv[i].we, tv[i].wd, n_rdy, n_other, n_stb, sa, sd);
      chk($sformatf("vec%0d_ready_edge", i), n_rdy, L + 1);
      chk($sformatf("vec%0d_other_ready", i), n_other, 0);
      chk($sformatf("vec%0d_strobes", i), n_stb, tv[i].we ? 1 : 0);
      if (tv[i].we) begin
        chk($sformatf("vec%0d_stb_addr", i), sa, tv[i].addr);
        chk($sformatf("vec%0d_stb_data", i), sd, tv[i].wd);
      end
      chk($sformatf("vec%0d_rdata", i),
          tv[i].id ? bif.req1_memory_read_data : bif.req0_memory_read_data, tv[i].exp_rd);
    end

    // Contention from reset with both requests held: grants alternate 0,1,0,1.
    do_reset();
    set_req(0, 1, 32'h30, 0, 0);
    set_req(1, 1, 32'h31, 0, 0);
    nr = 0;
    for (int c = 1; c <= 4 * (L + 2) + L + 6 && nr < 4; c++) begin
      tick();
      if (bif.req0_memory_ready) begin
        order[nr] = 0; when[nr] = c; nr++; set_req(0, 1, 32'h32 + c, 0, 0);
      end
      if (bif.req1_memory_ready && nr < 4) begin
        order[nr] = 1; when[nr] = c; nr++; set_req(1, 1, 32'h52 + c, 0, 0);
      end
    end
    chk("contend_count", nr, 4);
    for (int k = 0; k < 4 && k < nr; k++) begin
      chk($sformatf("contend_order%0d", k), order[k], k % 2);
      chk($sformatf("contend_edge%0d", k), when[k], 1 + L + k * (L + 2));
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick();
    tick();

    // Abort one cycle into WAIT: no ready, no strobe, pointer kept on req0.
    do_reset();
    set_req(0, 1, 32'h40, 1, 32'h55AA_55AA);
    tick();
    chk("abort_busy_wait", bif.busy, 1);
    set_req(0, 0, 0, 0, 0);
    tick();
    chk("abort_busy_fall", bif.busy, 0);
    nr = 0; stb = 0;
    for (int c = 0; c < L + 3; c++) begin
      if (bif.req0_memory_ready || bif.req1_memory_ready) nr++;
      if (bif.memory_write_enable) stb++;
      tick();
    end
    chk("abort_no_ready", nr, 0);
    chk("abort_no_strobe", stb, 0);
    set_req(0, 1, 32'h41, 0, 0);
    set_req(1, 1, 32'h42, 0, 0);
    first = -1; nr = 0;
    for (int c = 0; c < 3 * (L + 3) && nr < 2; c++) begin
      tick();
      if (bif.req0_memory_ready) begin
        if (first < 0) first = 0;
        nr++; set_req(0, 0, 0, 0, 0);
      end
      if (bif.req1_memory_ready) begin
        if (first < 0) first = 1;
        nr++; set_req(1, 0, 0, 0, 0);
      end
    end
    chk("abort_ptr_kept", first, 0);
    chk("abort_both_served", nr, 2);
    tick();

    // Line fills: req0 alone, then with one req1 read interleaved.
    for (int i = 0; i < 4; i++) preset(32'h80 + i, pat(32'h80 + i));
    line_fill(32'h80, 1'b0, t0, t1, t2);
    chk("fill_total_span", t1 - t0, 3 * (L + 2));
    for (int i = 0; i < 4; i++) preset(32'h90 + i, pat(32'h90 + i));
    preset(32'hA0, 32'h0BAD_F00D);
    line_fill(32'h90, 1'b1, t0, t1, t2);
    chk("fill_r1_after_first", (t2 > t0) ? 1 : 0, 1);
    chk("fill_r1_before_last", (t2 < t1 && t2 > 0) ? 1 : 0, 1);

    // Reset while in WAIT with a write pending.
    set_req(0, 1, 32'h60, 1, 32'h1111_1111);
    tick();
    tick();
    chk("rstwait_busy", bif.busy, 1);
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0);
    tick();
    chk_reset_outputs("rstwait");
    rst_n = 1'b1;
    nr = 0; stb = 0;
    for (int c = 0; c < L + 4; c++) begin
      tick();
      if (bif.req0_memory_ready || bif.req1_memory_ready) nr++;
      if (bif.memory_write_enable) stb++;
    end
    chk("rstwait_no_ready", nr, 0);
    chk("rstwait_no_strobe", stb, 0);

    // Random traffic scored by the model, with one reset pulse mid-stream.
    for (int c = 0; c < 1500; c++) begin
      rst_n = (c == 700) ? 1'b0 : 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
        logic r;
        int   u;
        r = (i == 0) ? bif.req0_memory_request : bif.req1_memory_request;
        u = $urandom_range(0, 99);
        if (!r) begin
          if (u < 35)
            set_req(i, 1, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 15),
                    1'($urandom_range(0, 1)), $urandom);
        end else if (get_rdy(i)) begin
          if (u < 50) set_req(i, 0, 0, 0, 0);
          else set_req(i, 1, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 15),
                       1'($urandom_range(0, 1)), $urandom);
        end else if (u < 4) begin
          set_req(i, 0, 0, 0, 0);
        end else if (u < 12) begin
          set_req(i, 1, $urandom, 1'($urandom_range(0, 1)), $urandom);
        end
      end
    end
    rst_n = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    for (int c = 0; c < L + 4; c++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
